// File: rtl/ts_cc_pid_monitor_if.sv
// ---------------------------------------------------------------------------
// ts_cc_pid_monitor_if
// Groups the TS byte stream, the PID table config/readback port and the
// continuity-check status outputs of ts_cc_pid_monitor.
//   master : stream/config source and status sink (e.g. testbench, host)
//   slave  : the monitor itself
// Signals:
//   sync, valid, data            TS byte stream (sync marks the 0x47 byte)
//   cfg_we, cfg_idx, cfg_pid,
//   cfg_en                       PID table entry write
//   rd_idx, rd_err_cnt           per-entry error count readback
//   cc_err, cc_err_idx           continuity error pulse and entry index
//   total_err, frame_err         saturating global counters
//   pkt_done                     packet check completed pulse
// ---------------------------------------------------------------------------
interface ts_cc_pid_monitor_if;
    logic        sync;
    logic        valid;
    logic [7:0]  data;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [12:0] cfg_pid;
    logic        cfg_en;
    logic [2:0]  rd_idx;
    logic [7:0]  rd_err_cnt;
    logic        cc_err;
    logic [2:0]  cc_err_idx;
    logic [15:0] total_err;
    logic [7:0]  frame_err;
    logic        pkt_done;

    modport master (
        output sync, valid, data,
        output cfg_we, cfg_idx, cfg_pid, cfg_en,
        output rd_idx,
        input  rd_err_cnt, cc_err, cc_err_idx, total_err, frame_err, pkt_done
    );

    modport slave (
        input  sync, valid, data,
        input  cfg_we, cfg_idx, cfg_pid, cfg_en,
        input  rd_idx,
        output rd_err_cnt, cc_err, cc_err_idx, total_err, frame_err, pkt_done
    );
endinterface

// File: rtl/ts_cc_pid_monitor.sv
// ---------------------------------------------------------------------------
// ts_cc_pid_monitor
// Per-PID continuity-counter checker for an MPEG-2 transport stream.
// Frames 188-byte packets from the sync strobe, captures TEI/PID/afc/cc from
// header bytes 1..3, looks the PID up in an 8-entry table (lowest matching
// enabled entry wins) and applies the continuity rules, keeping per-entry
// last CC, duplicate flag and saturating error count.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ts_cc_pid_monitor_if.slave (stream, config, readback, status)
// ---------------------------------------------------------------------------
module ts_cc_pid_monitor #(
    parameter int unsigned NUM_PIDS = 8,
    parameter int unsigned PKT_LEN  = 188
) (
    input  logic                  clk,
    input  logic                  rst,
    ts_cc_pid_monitor_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOOKUP,
        S_UPDATE,
        S_SKIP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_idx;
    logic        r_tei;
    logic [12:0] r_pid;
    logic [1:0]  r_afc;
    logic [3:0]  r_cc;
    logic        r_hit;
    logic [2:0]  r_hit_idx;

    // PID table
    logic [12:0] r_tbl_pid     [NUM_PIDS];
    logic        r_tbl_en      [NUM_PIDS];
    logic        r_tbl_seen    [NUM_PIDS];
    logic        r_tbl_dup     [NUM_PIDS];
    logic [3:0]  r_tbl_last_cc [NUM_PIDS];
    logic [7:0]  r_tbl_err     [NUM_PIDS];

    logic [7:0]  r_rd_err_cnt;
    logic        r_cc_err;
    logic [2:0]  r_cc_err_idx;
    logic [15:0] r_total_err;
    logic [7:0]  r_frame_err;
    logic        r_pkt_done;

    logic        w_sop;
    logic        w_premature;
    logic        w_last_byte;
    logic        w_match;
    logic [2:0]  w_match_idx;
    logic        w_upd;
    logic        w_hit_upd;
    logic        w_err_evt;
    logic        w_cfg_hit;
    logic        w_chk_err;
    logic [3:0]  w_new_last_cc;
    logic        w_new_dup;
    logic [3:0]  w_cc_inc;

    assign w_sop       = bus.valid & bus.sync;
    // Outside IDLE the index is never 0, so any sync there is premature.
    assign w_premature = (r_state != S_IDLE) && w_sop && (r_idx != 8'd0);
    assign w_last_byte = (r_idx == 8'(PKT_LEN - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_sop) w_next = S_HDR;
            S_HDR:    if (bus.valid && r_idx == 8'd3) w_next = S_LOOKUP;
            S_LOOKUP: w_next = S_UPDATE;
            S_UPDATE: w_next = S_SKIP;
            S_SKIP:   if (bus.valid && w_last_byte) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_premature) w_next = S_HDR;
    end

    // ------------------------------------------- byte index and header fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
            r_tei <= 1'b0;
            r_pid <= '0;
            r_afc <= '0;
            r_cc  <= '0;
        end else begin
            if (w_premature || (r_state == S_IDLE && w_sop)) begin
                r_idx <= 8'd1;
            end else if (r_state != S_IDLE && bus.valid) begin
                r_idx <= (r_state == S_SKIP && w_last_byte) ? '0 : r_idx + 8'd1;
            end

            if (r_state == S_HDR && bus.valid && !w_premature) begin
                case (r_idx)
                    8'd1: begin
                        r_tei       <= bus.data[7];
                        r_pid[12:8] <= bus.data[4:0];
                    end
                    8'd2: r_pid[7:0] <= bus.data;
                    8'd3: begin
                        r_afc <= bus.data[5:4];
                        r_cc  <= bus.data[3:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------- lookup
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int unsigned i = 0; i < NUM_PIDS; i++) begin
            if (!w_match && r_tbl_en[i] && r_tbl_pid[i] == r_pid) begin
                w_match     = 1'b1;
                w_match_idx = 3'(i);
            end
        end
    end

    // Ignore rules (TEI, null PID, no match) fold into the registered hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
        end else if (r_state == S_LOOKUP) begin
            r_hit     <= w_match && !r_tei && (r_pid != 13'h1FFF);
            r_hit_idx <= w_match_idx;
        end
    end

    // ------------------------------------------------------ continuity rules
    assign w_cc_inc = r_tbl_last_cc[r_hit_idx] + 4'd1;

    always_comb begin
        w_chk_err     = 1'b0;
        w_new_last_cc = r_tbl_last_cc[r_hit_idx];
        w_new_dup     = r_tbl_dup[r_hit_idx];
        if (!r_tbl_seen[r_hit_idx]) begin
            w_new_last_cc = r_cc;
            w_new_dup     = 1'b0;
        end else if (!r_afc[0]) begin
            w_chk_err = (r_cc != r_tbl_last_cc[r_hit_idx]);
        end else if (r_cc == w_cc_inc) begin
            w_new_last_cc = r_cc;
            w_new_dup     = 1'b0;
        end else if (r_cc == r_tbl_last_cc[r_hit_idx]) begin
            if (r_tbl_dup[r_hit_idx]) begin
                w_chk_err = 1'b1;
            end else begin
                w_new_dup = 1'b1;
            end
        end else begin
            w_chk_err     = 1'b1;
            w_new_last_cc = r_cc;
            w_new_dup     = 1'b0;
        end
    end

    // An abandoned packet (premature sync during UPDATE) has no effect at all.
    assign w_upd     = (r_state == S_UPDATE) && !w_premature;
    assign w_hit_upd = w_upd && r_hit;
    assign w_err_evt = w_hit_upd && w_chk_err;
    assign w_cfg_hit = bus.cfg_we && (bus.cfg_idx == r_hit_idx);

    // -------------------------------------------------------------- table
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PIDS; i++) begin
                r_tbl_pid[i]     <= '0;
                r_tbl_en[i]      <= 1'b0;
                r_tbl_seen[i]    <= 1'b0;
                r_tbl_dup[i]     <= 1'b0;
                r_tbl_last_cc[i] <= '0;
                r_tbl_err[i]     <= '0;
            end
        end else begin
            if (bus.cfg_we) begin
                r_tbl_pid[bus.cfg_idx]  <= bus.cfg_pid;
                r_tbl_en[bus.cfg_idx]   <= bus.cfg_en;
                r_tbl_seen[bus.cfg_idx] <= 1'b0;
                r_tbl_dup[bus.cfg_idx]  <= 1'b0;
                r_tbl_err[bus.cfg_idx]  <= '0;
            end
            // A config write to the same entry takes precedence over the check.
            if (w_hit_upd && !w_cfg_hit) begin
                r_tbl_seen[r_hit_idx]    <= 1'b1;
                r_tbl_dup[r_hit_idx]     <= w_new_dup;
                r_tbl_last_cc[r_hit_idx] <= w_new_last_cc;
                if (w_chk_err && r_tbl_err[r_hit_idx] != 8'hFF) begin
                    r_tbl_err[r_hit_idx] <= r_tbl_err[r_hit_idx] + 8'd1;
                end
            end
        end
    end

    // ----------------------------------------------------- status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_err_cnt <= '0;
            r_cc_err     <= 1'b0;
            r_cc_err_idx <= '0;
            r_total_err  <= '0;
            r_frame_err  <= '0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_rd_err_cnt <= r_tbl_err[bus.rd_idx];
            r_cc_err     <= w_err_evt;
            r_pkt_done   <= w_upd;
            if (w_err_evt) begin
                r_cc_err_idx <= r_hit_idx;
                if (r_total_err != 16'hFFFF) r_total_err <= r_total_err + 16'd1;
            end
            if (w_premature && r_frame_err != 8'hFF) begin
                r_frame_err <= r_frame_err + 8'd1;
            end
        end
    end

    assign bus.rd_err_cnt = r_rd_err_cnt;
    assign bus.cc_err     = r_cc_err;
    assign bus.cc_err_idx = r_cc_err_idx;
    assign bus.total_err  = r_total_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_ts_cc_pid_monitor.sv
// ---------------------------------------------------------------------------
// tb_ts_cc_pid_monitor
// Directed testbench for ts_cc_pid_monitor: in-order CC, gaps, duplicates,
// wrap, no-payload packets, ignore rules, lowest-index match, premature sync,
// saturation, config/update collision and mid-packet reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ts_cc_pid_monitor;

    logic clk;
    logic rst;
    ts_cc_pid_monitor_if bus ();

    ts_cc_pid_monitor #(.NUM_PIDS(8), .PKT_LEN(188)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Pulse monitor, sampled on the falling edge.
    int         n_done = 0;
    int         n_err  = 0;
    logic [2:0] last_err_idx = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.pkt_done) n_done++;
        if (bus.cc_err) begin
            n_err++;
            last_err_idx = bus.cc_err_idx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        bus.sync  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [12:0] pid, input logic en);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = idx;
        bus.cfg_pid = pid;
        bus.cfg_en  = en;
        tick();
        bus.cfg_we  = 1'b0;
    endtask

    // Sends the first nbytes of a packet; a config write of entry 0 to PID
    // 0x100 is issued alongside byte cfg_byte (use -1 for none).
    task automatic send(input logic [12:0] pid, input logic tei, input logic [1:0] afc,
                        input logic [3:0] cc, input int nbytes, input int cfg_byte);
        for (int i = 0; i < nbytes; i++) begin
            bus.valid = 1'b1;
            bus.sync  = (i == 0);
            case (i)
                0:       bus.data = 8'h47;
                1:       bus.data = {tei, 2'b00, pid[12:8]};
                2:       bus.data = pid[7:0];
                3:       bus.data = {2'b00, afc, cc};
                default: bus.data = 8'(i);
            endcase
            if (i == cfg_byte) begin
                bus.cfg_we  = 1'b1;
                bus.cfg_idx = 3'd0;
                bus.cfg_pid = 13'h0100;
                bus.cfg_en  = 1'b1;
            end else begin
                bus.cfg_we  = 1'b0;
            end
            tick();
        end
        bus.valid  = 1'b0;
        bus.sync   = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic pkt(input logic [12:0] pid, input logic [1:0] afc, input logic [3:0] cc);
        send(pid, 1'b0, afc, cc, 188, -1);
    endtask

    task automatic read_err(input logic [2:0] idx, output logic [7:0] v);
        bus.rd_idx = idx;
        tick();
        tick();
        v = bus.rd_err_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        checks++; if (bus.cc_err !== 1'b0) begin failures++; $display("FAIL reset_cc_err got=%0d exp=0", bus.cc_err); end
        checks++; if (bus.pkt_done !== 1'b0) begin failures++; $display("FAIL reset_pkt_done got=%0d exp=0", bus.pkt_done); end
        checks++; if (bus.total_err !== 16'd0) begin failures++; $display("FAIL reset_total_err got=%0d exp=0", bus.total_err); end
        checks++; if (bus.frame_err !== 8'd0) begin failures++; $display("FAIL reset_frame_err got=%0d exp=0", bus.frame_err); end
        checks++; if (bus.rd_err_cnt !== 8'd0) begin failures++; $display("FAIL reset_rd_err_cnt got=%0d exp=0", bus.rd_err_cnt); end
        checks++; if (bus.cc_err_idx !== 3'd0) begin failures++; $display("FAIL reset_cc_err_idx got=%0d exp=0", bus.cc_err_idx); end
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_in_order();
        int d0, e0;
        cfg(3'd0, 13'h0100, 1'b1);
        d0 = n_done; e0 = n_err;
        for (int i = 0; i < 4; i++) pkt(13'h0100, 2'b01, 4'(i));
        idle(3);
        checks++; if (n_done - d0 !== 4) begin failures++; $display("FAIL inorder_pkt_done got=%0d exp=4", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL inorder_cc_err got=%0d exp=0", n_err - e0); end
        checks++; if (bus.total_err !== 16'd0) begin failures++; $display("FAIL inorder_total got=%0d exp=0", bus.total_err); end
    endtask

    task automatic test_gap_dup();
        int e0;
        logic [7:0] v;
        cfg(3'd0, 13'h0100, 1'b1);
        e0 = n_err;
        pkt(13'h0100, 2'b01, 4'd5);
        pkt(13'h0100, 2'b01, 4'd6);
        pkt(13'h0100, 2'b01, 4'd9);
        idle(3);
        read_err(3'd0, v);
        checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL gap_cc_err got=%0d exp=1", n_err - e0); end
        checks++; if (last_err_idx !== 3'd0) begin failures++; $display("FAIL gap_err_idx got=%0d exp=0", last_err_idx); end
        checks++; if (v !== 8'd1) begin failures++; $display("FAIL gap_rd_err got=%0d exp=1", v); end
        checks++; if (bus.total_err !== 16'd1) begin failures++; $display("FAIL gap_total got=%0d exp=1", bus.total_err); end
        pkt(13'h0100, 2'b01, 4'd9);
        idle(3);
        checks++; if (bus.total_err !== 16'd1) begin failures++; $display("FAIL dup_tolerated_total got=%0d exp=1", bus.total_err); end
        pkt(13'h0100, 2'b01, 4'd9);
        idle(3);
        read_err(3'd0, v);
        checks++; if (bus.total_err !== 16'd2) begin failures++; $display("FAIL dup_second_total got=%0d exp=2", bus.total_err); end
        checks++; if (v !== 8'd2) begin failures++; $display("FAIL dup_second_rd_err got=%0d exp=2", v); end
    endtask

    task automatic test_wrap_nopayload();
        int e0;
        logic [7:0] v;
        cfg(3'd0, 13'h0100, 1'b1);
        e0 = n_err;
        pkt(13'h0100, 2'b01, 4'd14);
        pkt(13'h0100, 2'b11, 4'd15);
        pkt(13'h0100, 2'b01, 4'd0);
        idle(3);
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL wrap_cc_err got=%0d exp=0", n_err - e0); end
        pkt(13'h0100, 2'b10, 4'd0);
        idle(3);
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL nopay_same_cc_err got=%0d exp=0", n_err - e0); end
        pkt(13'h0100, 2'b10, 4'd3);
        idle(3);
        read_err(3'd0, v);
        checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL nopay_diff_cc_err got=%0d exp=1", n_err - e0); end
        checks++; if (bus.total_err !== 16'd3) begin failures++; $display("FAIL nopay_total got=%0d exp=3", bus.total_err); end
        checks++; if (v !== 8'd1) begin failures++; $display("FAIL nopay_rd_err got=%0d exp=1", v); end
        // last_cc stayed 0 through the no-payload error
        pkt(13'h0100, 2'b01, 4'd1);
        idle(3);
        checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL nopay_lastcc_kept got=%0d exp=1", n_err - e0); end
    endtask

    task automatic test_ignore();
        int d0, e0;
        logic [7:0] v;
        d0 = n_done; e0 = n_err;
        send(13'h0100, 1'b1, 2'b01, 4'd7, 188, -1);
        pkt(13'h1FFF, 2'b01, 4'd7);
        pkt(13'h0200, 2'b01, 4'd7);
        idle(3);
        checks++; if (n_done - d0 !== 3) begin failures++; $display("FAIL ignore_pkt_done got=%0d exp=3", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL ignore_cc_err got=%0d exp=0", n_err - e0); end
        pkt(13'h0100, 2'b01, 4'd2);
        idle(3);
        read_err(3'd0, v);
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL ignore_table_kept got=%0d exp=0", n_err - e0); end
        checks++; if (v !== 8'd1) begin failures++; $display("FAIL ignore_rd_err got=%0d exp=1", v); end
        checks++; if (bus.total_err !== 16'd3) begin failures++; $display("FAIL ignore_total got=%0d exp=3", bus.total_err); end
    endtask

    task automatic test_lowest_match();
        logic [7:0] v;
        cfg(3'd3, 13'h0300, 1'b1);
        cfg(3'd5, 13'h0300, 1'b1);
        pkt(13'h0300, 2'b01, 4'd0);
        pkt(13'h0300, 2'b01, 4'd4);
        idle(3);
        checks++; if (last_err_idx !== 3'd3) begin failures++; $display("FAIL match_err_idx got=%0d exp=3", last_err_idx); end
        checks++; if (bus.total_err !== 16'd4) begin failures++; $display("FAIL match_total got=%0d exp=4", bus.total_err); end
        read_err(3'd3, v);
        checks++; if (v !== 8'd1) begin failures++; $display("FAIL match_rd_err3 got=%0d exp=1", v); end
        read_err(3'd5, v);
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL match_rd_err5 got=%0d exp=0", v); end
    endtask

    task automatic test_premature();
        int d0, e0;
        d0 = n_done; e0 = n_err;
        send(13'h0100, 1'b0, 2'b01, 4'd9, 2, -1);
        pkt(13'h0100, 2'b01, 4'd3);
        idle(3);
        checks++; if (bus.frame_err !== 8'd1) begin failures++; $display("FAIL premature_hdr_frame got=%0d exp=1", bus.frame_err); end
        checks++; if (n_done - d0 !== 1) begin failures++; $display("FAIL premature_hdr_done got=%0d exp=1", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL premature_hdr_cc_err got=%0d exp=0", n_err - e0); end
        d0 = n_done;
        send(13'h0100, 1'b0, 2'b01, 4'd4, 100, -1);
        pkt(13'h0100, 2'b01, 4'd5);
        idle(3);
        checks++; if (bus.frame_err !== 8'd2) begin failures++; $display("FAIL premature_100_frame got=%0d exp=2", bus.frame_err); end
        checks++; if (n_done - d0 !== 2) begin failures++; $display("FAIL premature_100_done got=%0d exp=2", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL premature_100_cc_err got=%0d exp=0", n_err - e0); end
    endtask

    // Six-byte packets cut short by the next sync: the header is fully
    // checked before the premature sync arrives.
    task automatic test_saturation();
        int e0;
        logic [7:0] v;
        cfg(3'd0, 13'h0100, 1'b1);
        e0 = n_err;
        for (int i = 0; i < 301; i++) send(13'h0100, 1'b0, 2'b01, 4'((2 * i) % 16), 6, -1);
        idle(3);
        read_err(3'd0, v);
        checks++; if (v !== 8'd255) begin failures++; $display("FAIL sat_rd_err got=%0d exp=255", v); end
        checks++; if (n_err - e0 !== 300) begin failures++; $display("FAIL sat_cc_err got=%0d exp=300", n_err - e0); end
        checks++; if (bus.total_err !== 16'd304) begin failures++; $display("FAIL sat_total got=%0d exp=304", bus.total_err); end
        checks++; if (bus.frame_err !== 8'd255) begin failures++; $display("FAIL sat_frame got=%0d exp=255", bus.frame_err); end
    endtask

    task automatic test_cfg_collision();
        int e0;
        logic [7:0] v;
        cfg(3'd0, 13'h0100, 1'b1);
        e0 = n_err;
        pkt(13'h0100, 2'b01, 4'd0);
        // byte 5 is accepted on the edge that closes the UPDATE cycle
        send(13'h0100, 1'b0, 2'b01, 4'd5, 188, 5);
        idle(3);
        read_err(3'd0, v);
        checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL coll_cc_err got=%0d exp=1", n_err - e0); end
        checks++; if (bus.total_err !== 16'd305) begin failures++; $display("FAIL coll_total got=%0d exp=305", bus.total_err); end
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL coll_rd_err got=%0d exp=0", v); end
        checks++; if (bus.frame_err !== 8'd255) begin failures++; $display("FAIL coll_frame_hold got=%0d exp=255", bus.frame_err); end
        // seen was cleared: 9 is recorded, 10 follows in order
        pkt(13'h0100, 2'b01, 4'd9);
        pkt(13'h0100, 2'b01, 4'd10);
        idle(3);
        checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL coll_seen_cleared got=%0d exp=1", n_err - e0); end
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        logic [7:0] v;
        send(13'h0100, 1'b0, 2'b01, 4'd11, 50, -1);
        rst = 1'b0;
        #1;
        checks++; if (bus.total_err !== 16'd0) begin failures++; $display("FAIL rstmid_total got=%0d exp=0", bus.total_err); end
        checks++; if (bus.frame_err !== 8'd0) begin failures++; $display("FAIL rstmid_frame got=%0d exp=0", bus.frame_err); end
        checks++; if (bus.cc_err_idx !== 3'd0) begin failures++; $display("FAIL rstmid_err_idx got=%0d exp=0", bus.cc_err_idx); end
        checks++; if (bus.rd_err_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_rd_err got=%0d exp=0", bus.rd_err_cnt); end
        checks++; if (bus.pkt_done !== 1'b0 || bus.cc_err !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got=%0d%0d exp=00", bus.pkt_done, bus.cc_err); end
        idle(2);
        rst = 1'b1;
        idle(2);
        // Table was cleared: PID 0x300 no longer matches, entry 3 count is 0.
        d0 = n_done; e0 = n_err;
        pkt(13'h0300, 2'b01, 4'd0);
        pkt(13'h0300, 2'b01, 4'd7);
        idle(3);
        read_err(3'd3, v);
        checks++; if (n_done - d0 !== 2) begin failures++; $display("FAIL rstmid_done got=%0d exp=2", n_done - d0); end
        checks++; if (n_err - e0 !== 0) begin failures++; $display("FAIL rstmid_no_match got=%0d exp=0", n_err - e0); end
        checks++; if (v !== 8'd0) begin failures++; $display("FAIL rstmid_rd_err3 got=%0d exp=0", v); end
    endtask

    initial begin
        rst         = 1'b0;
        bus.sync    = 1'b0;
        bus.valid   = 1'b0;
        bus.data    = '0;
        bus.cfg_we  = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_pid = '0;
        bus.cfg_en  = 1'b0;
        bus.rd_idx  = '0;
        #3;
        test_reset();
        test_in_order();
        test_gap_dup();
        test_wrap_nopayload();
        test_ignore();
        test_lowest_match();
        test_premature();
        test_saturation();
        test_cfg_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ts_cc_pid_monitor.md
# ts_cc_pid_monitor

Continuity-check controller for an MPEG-2 transport stream byte stream. It frames 188-byte TS packets, extracts PID, TEI, adaptation_field_control and continuity_counter, and looks each packet up in an 8-entry PID table. Per-PID table entries hold last CC, a duplicate flag and a saturating error count. It sits after the sync detector and runs the per-PID continuity check, replacing the single-stream packet loss counter when multiple PIDs must be monitored.

## Interface
- NUM_PIDS, 8: table entries; fixed at 8 because index ports are 3 bits.
- PKT_LEN, 188: TS packet length in bytes.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- sync  in  1  high on the 0x47 byte of a packet; qualified by valid.
- valid  in  1  data byte strobe.
- data  in  8  stream byte.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  3  entry written.
- cfg_pid  in  13  PID for entry.
- cfg_en  in  1  entry enable.
- rd_idx  in  3  entry selected for readback.
- rd_err_cnt  out  8  error count of entry rd_idx, registered.
- cc_err  out  1  one-cycle pulse on continuity error.
- cc_err_idx  out  3  entry that erred; valid while cc_err=1, holds otherwise.
- total_err  out  16  saturating sum of all CC errors.
- frame_err  out  8  saturating count of premature sync events.
- pkt_done  out  1  one-cycle pulse when a packet's check completes.

## Operation
- Reset values: all outputs 0; table pid=0, en=0, seen=0, dup=0, last_cc=0, err=0; FSM=IDLE; byte index=0.
- Byte index counts accepted bytes (valid=1) from the sync byte (index 0) to 187, in every state except IDLE.
- Header fields:
  - byte1: TEI=data[7], PID[12:8]=data[4:0].
  - byte2: PID[7:0].
  - byte3: afc=data[5:4], cc=data[3:0].
- FSM states:
  - IDLE: on valid&sync, index<=1 and go to HDR.
  - HDR: capture bytes 1..3. The byte-3 accept moves the FSM to LOOKUP.
  - LOOKUP: one cycle, regardless of valid. Match is the lowest-index entry with en=1 and pid==PID. Match result is registered.
  - UPDATE: one cycle. Applies the check rules, writes the table, generates pulses, then goes to SKIP.
  - SKIP: consume bytes until index 187 is accepted, then go to IDLE.
- Packets are ignored (no table change, no error; pkt_done still pulses) when any of these holds:
  - TEI=1;
  - PID=0x1FFF;
  - no entry matches.
- Check rules in UPDATE for a matched entry:
  - seen=0: record cc, set seen=1, clear dup, no error.
  - afc[0]=0 (no payload): error if cc!=last_cc; last_cc unchanged.
  - payload, cc==last_cc+1 (mod 16): no error, last_cc<=cc, dup<=0.
  - payload, cc==last_cc, dup=0: tolerated duplicate, dup<=1.
  - payload, cc==last_cc, dup=1: error.
  - any other payload cc: error, last_cc<=cc, dup<=0.
- On an error:
  - entry err increments, saturating at 255;
  - total_err increments, saturating at 65535;
  - cc_err pulses and cc_err_idx takes the entry index.
- Premature sync: valid&sync in HDR, LOOKUP, UPDATE or SKIP at index≠0.
  - frame_err increments (saturating at 255).
  - The packet in progress is abandoned with no table update and no pkt_done.
  - The new byte is treated as index 0 and the FSM goes to HDR.
- Config write: cfg_we sets pid/en of entry cfg_idx and clears seen, dup, err.
  - If an UPDATE to the same index falls in the same cycle, the config write wins and the UPDATE is dropped.
  - cc_err and total_err still reflect the check result.
- rd_err_cnt <= err[rd_idx] every cycle (1-cycle read latency). A same-cycle table write becomes visible one cycle later.

## Timing
- Byte-3 accept at edge N: LOOKUP during cycle N..N+1, UPDATE during N+1..N+2.
- cc_err, pkt_done and table/counter updates are visible after edge N+2.
- Payload bytes arriving during LOOKUP/UPDATE are counted normally and need no stall; there is no backpressure.
- Minimum packet spacing is none: the sync byte may arrive in the cycle after index 187.
- Reset asserted mid-packet: immediate return to reset values. The next packet is checked only after a new sync.

## Test plan
- Entry 0 = PID 0x0100 enabled; 4 packets with cc 0,1,2,3 and afc=01 -> no cc_err, total_err=0, pkt_done pulses 4 times.
- Same PID, cc sequence 5,6,9 -> one cc_err with cc_err_idx=0, rd_err_cnt(0)=1, total_err=1. Then cc 9,9,9 -> first 9 tolerated, second 9 errors, total_err=2.
- Wrap and no-payload: cc 14,15,0 with payload -> no error. Then afc=10 with cc 0 -> no error; afc=10 with cc 3 -> error.
- Ignore cases: TEI=1 packet with bad cc, PID 0x1FFF packet, and packet with unmatched PID 0x0200 -> no cc_err, table unchanged, 3 pkt_done pulses.
- Sync at byte index 100 -> frame_err=1, no pkt_done for the truncated packet, next packet checked normally. 300 consecutive bad-cc packets -> rd_err_cnt saturates at 255.
- cfg_we to entry 0 in the UPDATE cycle of an erroring packet -> entry err=0 and seen=0 afterward, total_err still +1. Reset low mid-SKIP -> all outputs 0 on the next observed cycle.
